// File: rtl/tt_um_jleugeri_ttt_bitvec_iter.sv
// rtl/tt_um_jleugeri_ttt_bitvec_iter.sv - set-bit iterator: captures a vector, emits one set-bit index per handshake
module tt_um_jleugeri_ttt_bitvec_iter #(
  parameter int SIZE  = 16,
  parameter int ORDER = 0,
  parameter int IW    = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in_vec,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic [IW-1:0]   out_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            nonempty,
  output logic [IW:0]     remaining,
  output logic            done
);

  logic [SIZE-1:0]   pending_q, pending_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              done_q, done_d;

  logic [IW:0]       cnt;
  logic [IW-1:0]     sel_idx;
  logic [IW-1:0]     rot_off;
  logic [2*SIZE-1:0] dbl;
  logic [SIZE-1:0]   rot;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < SIZE; i++) begin
      cnt = cnt + {{IW{1'b0}}, pending_q[i]};
    end
  end

  // Round-robin: rotate so ptr+1 sits at bit 0, take the lowest set bit, then map back modulo SIZE.
  always_comb begin
    sel_idx = '0;
    rot_off = '0;
    dbl     = {pending_q, pending_q};
    rot     = SIZE'(dbl >> ({1'b0, ptr_q} + 1'b1));
    if (ORDER == 1) begin
      for (int i = 0; i < SIZE; i++) begin
        if (pending_q[i]) sel_idx = IW'(i);
      end
    end else if (ORDER == 2) begin
      for (int j = SIZE - 1; j >= 0; j--) begin
        if (rot[j]) rot_off = IW'(j);
      end
      sel_idx = ptr_q + IW'(1) + rot_off;
    end else begin
      for (int i = SIZE - 1; i >= 0; i--) begin
        if (pending_q[i]) sel_idx = IW'(i);
      end
    end
  end

  assign nonempty  = |pending_q;
  assign out_valid = nonempty;
  assign in_ready  = !nonempty;
  assign remaining = cnt;
  assign out_last  = (cnt == (IW+1)'(1));
  assign out_idx   = nonempty ? sel_idx : '0;
  assign done      = done_q;

  // Flush wins over consume and load; consume and load are mutually exclusive via in_ready.
  always_comb begin
    pending_d = pending_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    if (flush) begin
      pending_d = '0;
      done_d    = nonempty;
    end else if (out_valid && out_ready) begin
      pending_d = pending_q & ~(SIZE'(1) << out_idx);
      if (ORDER == 2) ptr_d = out_idx;
      done_d    = out_last;
    end else if (in_valid && in_ready) begin
      pending_d = in_vec;
      done_d    = ~|in_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      ptr_q     <= IW'(SIZE - 1);
      done_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_bitvec_iter.sv
// tb/tb_tt_um_jleugeri_ttt_bitvec_iter.sv - self-checking bench, one instance per selection order
module tb_tt_um_jleugeri_ttt_bitvec_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_vec    [3];
  logic        in_valid  [3];
  logic        flush     [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic [3:0]  out_idx   [3];
  logic        out_valid [3];
  logic        out_last  [3];
  logic        nonempty  [3];
  logic [4:0]  remaining [3];
  logic        done      [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tt_um_jleugeri_ttt_bitvec_iter #(.SIZE(16), .ORDER(g)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_vec    (in_vec[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .flush     (flush[g]),
      .out_idx   (out_idx[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_last  (out_last[g]),
      .nonempty  (nonempty[g]),
      .remaining (remaining[g]),
      .done      (done[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference state: the set of pending indices, the last emitted index, and the done flag.
  logic [15:0] m_pend [3];
  int          m_ptr  [3];
  bit          m_done [3];

  typedef struct {
    int          order;
    logic [15:0] vec;
    int          n;
    int          seq [4];
  } vec_t;

  task automatic chk(input string name, input int o, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s order=%0d got=%0d expected=%0d t=%0t", name, o, act, exp, $time);
    end
  endtask

  function automatic int msel(input int o);
    if (m_pend[o] == 16'h0) return 0;
    if (o == 0) begin
      for (int i = 0; i < 16; i++) if (m_pend[o][i]) return i;
    end else if (o == 1) begin
      for (int i = 15; i >= 0; i--) if (m_pend[o][i]) return i;
    end else begin
      for (int k = 1; k <= 16; k++) if (m_pend[o][(m_ptr[o] + k) % 16]) return (m_ptr[o] + k) % 16;
    end
    return 0;
  endfunction

  // Compare every output against the reference, advance the reference, then cross one clock edge.
  task automatic step();
    logic [15:0] np [3];
    int          nptr [3];
    bit          nd [3];
    for (int o = 0; o < 3; o++) begin
      int s;
      int r;
      s = msel(o);
      r = $countones(m_pend[o]);
      chk("out_idx",   o, int'(out_idx[o]),   s);
      chk("out_valid", o, int'(out_valid[o]), int'(r != 0));
      chk("in_ready",  o, int'(in_ready[o]),  int'(r == 0));
      chk("nonempty",  o, int'(nonempty[o]),  int'(r != 0));
      chk("remaining", o, int'(remaining[o]), r);
      chk("out_last",  o, int'(out_last[o]),  int'(r == 1));
      chk("done",      o, int'(done[o]),      int'(m_done[o]));
      np[o] = m_pend[o];
      nptr[o] = m_ptr[o];
      nd[o] = 1'b0;
      if (rst) begin
        np[o] = 16'h0;
        nptr[o] = 15;
      end else if (flush[o]) begin
        np[o] = 16'h0;
        nd[o] = (r != 0);
      end else if (r != 0 && out_ready[o]) begin
        np[o][s] = 1'b0;
        nptr[o] = s;
        nd[o] = (r == 1);
      end else if (r == 0 && in_valid[o]) begin
        np[o] = in_vec[o];
        nd[o] = (in_vec[o] == 16'h0);
      end
    end
    @(posedge clk);
    #1;
    for (int o = 0; o < 3; o++) begin
      m_pend[o] = np[o];
      m_ptr[o]  = nptr[o];
      m_done[o] = nd[o];
    end
  endtask

  task automatic idle_inputs();
    for (int o = 0; o < 3; o++) begin
      in_vec[o] = 16'h0;
      in_valid[o] = 1'b0;
      flush[o] = 1'b0;
      out_ready[o] = 1'b0;
    end
  endtask

  task automatic load(input int o, input logic [15:0] v);
    in_vec[o] = v;
    in_valid[o] = 1'b1;
    step();
    in_valid[o] = 1'b0;
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = '{order: 0, vec: 16'h8421, n: 4, seq: '{0, 5, 10, 15}};
    tbl[1] = '{order: 1, vec: 16'h8421, n: 4, seq: '{15, 10, 5, 0}};
    tbl[2] = '{order: 2, vec: 16'h0006, n: 2, seq: '{1, 2, 0, 0}};
    tbl[3] = '{order: 2, vec: 16'h0007, n: 3, seq: '{0, 1, 2, 0}};
    tbl[4] = '{order: 2, vec: 16'h0104, n: 2, seq: '{8, 2, 0, 0}};

    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int o = 0; o < 3; o++) begin
      m_pend[o] = 16'h0;
      m_ptr[o] = 15;
      m_done[o] = 1'b0;
    end
    step();
    rst = 1'b0;
    for (int o = 0; o < 3; o++) begin
      chk("reset_in_ready", o, int'(in_ready[o]), 1);
      chk("reset_out_idx",  o, int'(out_idx[o]), 0);
    end

    // Directed sequences from the table, continuous out_ready.
    for (int t = 0; t < 5; t++) begin
      int o;
      o = tbl[t].order;
      load(o, tbl[t].vec);
      out_ready[o] = 1'b1;
      for (int k = 0; k < tbl[t].n; k++) begin
        chk("seq_idx",  o, int'(out_idx[o]),   tbl[t].seq[k]);
        chk("seq_last", o, int'(out_last[o]),  int'(k == tbl[t].n - 1));
        chk("seq_rem",  o, int'(remaining[o]), tbl[t].n - k);
        step();
      end
      out_ready[o] = 1'b0;
      chk("seq_done",     o, int'(done[o]), 1);
      chk("seq_in_ready", o, int'(in_ready[o]), 1);
      step();
      chk("seq_done_off", o, int'(done[o]), 0);
    end

    // Descending order with a three-cycle stall after the first index.
    load(1, 16'h8421);
    out_ready[1] = 1'b1;
    chk("stall_first", 1, int'(out_idx[1]), 15);
    step();
    out_ready[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_idx",  1, int'(out_idx[1]), 10);
      chk("stall_rem",  1, int'(remaining[1]), 3);
      chk("stall_last", 1, int'(out_last[1]), 0);
      step();
    end
    out_ready[1] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    out_ready[1] = 1'b0;
    chk("stall_done", 1, int'(done[1]), 1);
    step();

    // Empty load: no output handshake, single done pulse.
    load(0, 16'h0000);
    chk("empty_done",      0, int'(done[0]), 1);
    chk("empty_out_valid", 0, int'(out_valid[0]), 0);
    chk("empty_in_ready",  0, int'(in_ready[0]), 1);
    step();
    chk("empty_done_off",  0, int'(done[0]), 0);
    chk("empty_out_valid2", 0, int'(out_valid[0]), 0);

    // Flush together with out_ready after two consumes.
    load(0, 16'hFFFF);
    out_ready[0] = 1'b1;
    step();
    step();
    chk("flush_pre_rem", 0, int'(remaining[0]), 14);
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    out_ready[0] = 1'b0;
    chk("flush_rem",  0, int'(remaining[0]), 0);
    chk("flush_done", 0, int'(done[0]), 1);
    step();
    chk("flush_done_off", 0, int'(done[0]), 0);
    load(0, 16'h0001);
    chk("flush_reload", 0, int'(out_valid[0]), 1);
    out_ready[0] = 1'b1;
    step();
    step();
    out_ready[0] = 1'b0;

    // Reset mid-iteration with five bits pending.
    load(2, 16'h003F);
    out_ready[2] = 1'b1;
    step();
    out_ready[2] = 1'b0;
    chk("rst_pre_rem", 2, int'(remaining[2]), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_in_ready",  2, int'(in_ready[2]), 1);
    chk("rst_out_valid", 2, int'(out_valid[2]), 0);
    chk("rst_rem",       2, int'(remaining[2]), 0);
    chk("rst_done",      2, int'(done[2]), 0);
    load(2, 16'h8001);
    chk("rst_rr_first", 2, int'(out_idx[2]), 0);
    out_ready[2] = 1'b1;
    step();
    step();
    step();
    idle_inputs();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      for (int o = 0; o < 3; o++) begin
        case ($urandom_range(0, 3))
          0: in_vec[o] = 16'h0;
          1: in_vec[o] = 16'h1 << $urandom_range(0, 15);
          default: in_vec[o] = 16'($urandom);
        endcase
        in_valid[o]  = 1'($urandom_range(0, 1));
        out_ready[o] = ($urandom_range(0, 3) != 0);
        flush[o]     = ($urandom_range(0, 19) == 0);
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
